decode_stage: RTL and testbench

//  Pipelined Y86-64 decode stage: D pipeline register, 15x64 register file, and the operand forwarding network.

---
 rtl/y86_pkg.sv | 46 ++++
 rtl/reg_file.sv | 55 +++++
 rtl/decode_stage.sv | 128 ++++++++++++
 tb/tb_decode_stage.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 constants and the decode pipeline-register layout.
// Imported by the decode stage and its register file.
package y86_pkg;

  localparam int W    = 64;
  localparam int NREG = 15;

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'h4;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 4'd4;

  typedef struct packed {
    logic [2:0]   stat;
    logic [3:0]   icode;
    logic [3:0]   ifun;
    logic [3:0]   ra;
    logic [3:0]   rb;
    logic [W-1:0] valc;
    logic [W-1:0] valp;
  } d_reg_t;

  localparam d_reg_t D_NOP = '{stat: S_AOK, icode: I_NOP, ifun: 4'h0,
                               ra: RNONE, rb: RNONE, valc: 64'd0, valp: 64'd0};

  function automatic logic is_reg(input logic [3:0] id);
    return (id != RNONE);
  endfunction

endpackage

// File: rtl/reg_file.sv
// 15x64 architectural register file: two combinational read ports and two
// writeback ports, where port M overrides port E on a shared target.
module reg_file
  import y86_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [3:0]   src_a,
  input  logic [3:0]   src_b,
  input  logic [3:0]   dst_e,
  input  logic [W-1:0] val_e,
  input  logic [3:0]   dst_m,
  input  logic [W-1:0] val_m,
  output logic [W-1:0] rd_a,
  output logic [W-1:0] rd_b
);

  logic [W-1:0] regs_r [NREG];

  // Register storage; writebacks arriving with reset are dropped
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        regs_r[i] <= 64'd0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (dst_m == 4'(i)) begin
          regs_r[i] <= val_m;
        end else if (dst_e == 4'(i)) begin
          regs_r[i] <= val_e;
        end else begin
          regs_r[i] <= regs_r[i];
        end
      end
    end
  end

  // Read ports; id 15 has no storage behind it and reads as zero
  always_comb begin
    rd_a = 64'd0;
    rd_b = 64'd0;
    if (is_reg(src_a)) begin
      rd_a = regs_r[src_a];
    end else begin
      rd_a = 64'd0;
    end
    if (is_reg(src_b)) begin
      rd_b = regs_r[src_b];
    end else begin
      rd_b = 64'd0;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Y86-64 decode stage: D pipeline register, register-id decode, register
// file and the five-source operand forwarding network.
module decode_stage
  import y86_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic [2:0]   f_stat,
  input  logic [3:0]   f_icode,
  input  logic [3:0]   f_ifun,
  input  logic [3:0]   f_rA,
  input  logic [3:0]   f_rB,
  input  logic [W-1:0] f_valC,
  input  logic [W-1:0] f_valP,
  input  logic         D_stall,
  input  logic         D_bubble,
  input  logic [3:0]   e_dstE,
  input  logic [W-1:0] e_valE,
  input  logic [3:0]   M_dstM,
  input  logic [W-1:0] m_valM,
  input  logic [3:0]   M_dstE,
  input  logic [W-1:0] M_valE,
  input  logic [3:0]   W_dstM,
  input  logic [W-1:0] W_valM,
  input  logic [3:0]   W_dstE,
  input  logic [W-1:0] W_valE,
  output logic [2:0]   d_stat,
  output logic [3:0]   d_icode,
  output logic [3:0]   d_ifun,
  output logic [W-1:0] d_valC,
  output logic [W-1:0] d_valA,
  output logic [W-1:0] d_valB,
  output logic [3:0]   d_srcA,
  output logic [3:0]   d_srcB,
  output logic [3:0]   d_dstE,
  output logic [3:0]   d_dstM
);

  d_reg_t       d_r;
  logic [3:0]   src_a_s, src_b_s, dst_e_s, dst_m_s;
  logic [W-1:0] rf_a_s, rf_b_s;

  // Youngest in-flight producer wins; an absent source never matches
  function automatic logic [W-1:0] fwd_value(
    input logic [3:0] src,   input logic [W-1:0] rf_val,
    input logic [3:0] id_e,  input logic [W-1:0] v_e,
    input logic [3:0] id_mm, input logic [W-1:0] v_mm,
    input logic [3:0] id_me, input logic [W-1:0] v_me,
    input logic [3:0] id_wm, input logic [W-1:0] v_wm,
    input logic [3:0] id_we, input logic [W-1:0] v_we);
    if (!is_reg(src))      return 64'd0;
    else if (src == id_e)  return v_e;
    else if (src == id_mm) return v_mm;
    else if (src == id_me) return v_me;
    else if (src == id_wm) return v_wm;
    else if (src == id_we) return v_we;
    else                   return rf_val;
  endfunction

  // D pipeline register: reset > stall > bubble > load
  always_ff @(posedge clk) begin
    if (rst) begin
      d_r <= D_NOP;
    end else if (D_stall) begin
      d_r <= d_r;
    end else if (D_bubble) begin
      d_r <= D_NOP;
    end else begin
      d_r <= {f_stat, f_icode, f_ifun, f_rA, f_rB, f_valC, f_valP};
    end
  end

  // Register-id decode from the instruction class
  always_comb begin
    src_a_s = RNONE;
    src_b_s = RNONE;
    dst_e_s = RNONE;
    dst_m_s = RNONE;
    case (d_r.icode)
      I_RRMOVQ: begin src_a_s = d_r.ra; dst_e_s = d_r.rb; end
      I_IRMOVQ: begin dst_e_s = d_r.rb; end
      I_RMMOVQ: begin src_a_s = d_r.ra; src_b_s = d_r.rb; end
      I_MRMOVQ: begin src_b_s = d_r.rb; dst_m_s = d_r.ra; end
      I_OPQ:    begin src_a_s = d_r.ra; src_b_s = d_r.rb; dst_e_s = d_r.rb; end
      I_CALL:   begin src_b_s = RSP; dst_e_s = RSP; end
      I_RET:    begin src_a_s = RSP; src_b_s = RSP; dst_e_s = RSP; end
      I_PUSHQ:  begin src_a_s = d_r.ra; src_b_s = RSP; dst_e_s = RSP; end
      I_POPQ:   begin src_a_s = RSP; src_b_s = RSP; dst_e_s = RSP; dst_m_s = d_r.ra; end
      default:  begin src_a_s = RNONE; src_b_s = RNONE; dst_e_s = RNONE; dst_m_s = RNONE; end
    endcase
  end

  reg_file u_reg_file (
    .clk   (clk),
    .rst   (rst),
    .src_a (src_a_s),
    .src_b (src_b_s),
    .dst_e (W_dstE),
    .val_e (W_valE),
    .dst_m (W_dstM),
    .val_m (W_valM),
    .rd_a  (rf_a_s),
    .rd_b  (rf_b_s)
  );

  // Operand selection; jumps and calls carry the return address in valA
  always_comb begin
    d_valA = 64'd0;
    d_valB = fwd_value(src_b_s, rf_b_s, e_dstE, e_valE, M_dstM, m_valM,
                       M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
    if (d_r.icode == I_JXX || d_r.icode == I_CALL) begin
      d_valA = d_r.valp;
    end else begin
      d_valA = fwd_value(src_a_s, rf_a_s, e_dstE, e_valE, M_dstM, m_valM,
                         M_dstE, M_valE, W_dstM, W_valM, W_dstE, W_valE);
    end
  end

  assign d_stat  = d_r.stat;
  assign d_icode = d_r.icode;
  assign d_ifun  = d_r.ifun;
  assign d_valC  = d_r.valc;
  assign d_srcA  = src_a_s;
  assign d_srcB  = src_b_s;
  assign d_dstE  = dst_e_s;
  assign d_dstM  = dst_m_s;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios plus randomized
// traffic compared against an instruction-level reference model.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  f_stat;
  logic [3:0]  f_icode, f_ifun, f_rA, f_rB;
  logic [63:0] f_valC, f_valP;
  logic        D_stall, D_bubble;
  logic [3:0]  e_dstE, M_dstM, M_dstE, W_dstM, W_dstE;
  logic [63:0] e_valE, m_valM, M_valE, W_valM, W_valE;
  logic [2:0]  d_stat;
  logic [3:0]  d_icode, d_ifun, d_srcA, d_srcB, d_dstE, d_dstM;
  logic [63:0] d_valC, d_valA, d_valB;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  logic [63:0] m_rf [15];
  logic [2:0]  m_stat;
  logic [3:0]  m_icode, m_ifun, m_ra, m_rb;
  logic [63:0] m_valc, m_valp;

  decode_stage dut (
    .clk(clk), .rst(rst),
    .f_stat(f_stat), .f_icode(f_icode), .f_ifun(f_ifun), .f_rA(f_rA), .f_rB(f_rB),
    .f_valC(f_valC), .f_valP(f_valP), .D_stall(D_stall), .D_bubble(D_bubble),
    .e_dstE(e_dstE), .e_valE(e_valE), .M_dstM(M_dstM), .m_valM(m_valM),
    .M_dstE(M_dstE), .M_valE(M_valE), .W_dstM(W_dstM), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_valE(W_valE),
    .d_stat(d_stat), .d_icode(d_icode), .d_ifun(d_ifun), .d_valC(d_valC),
    .d_valA(d_valA), .d_valB(d_valB), .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_dstE(d_dstE), .d_dstM(d_dstM)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_nop();
    m_stat = 3'd1; m_icode = 4'h1; m_ifun = 4'h0;
    m_ra = 4'hF; m_rb = 4'hF; m_valc = 64'd0; m_valp = 64'd0;
  endtask

  // one clock edge: advance the reference model with the inputs applied to it
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 15; i++) m_rf[i] = 64'd0;
      model_nop();
    end else begin
      if (W_dstE != 4'hF) m_rf[W_dstE] = W_valE;
      if (W_dstM != 4'hF) m_rf[W_dstM] = W_valM;
      if (!D_stall) begin
        if (D_bubble) model_nop();
        else begin
          m_stat = f_stat; m_icode = f_icode; m_ifun = f_ifun;
          m_ra = f_rA; m_rb = f_rB; m_valc = f_valC; m_valp = f_valP;
        end
      end
    end
    @(negedge clk);
  endtask

  function automatic logic [63:0] lookup(input logic [3:0] s);
    logic [3:0]  ids  [5];
    logic [63:0] vals [5];
    ids  = '{e_dstE, M_dstM, M_dstE, W_dstM, W_dstE};
    vals = '{e_valE, m_valM, M_valE, W_valM, W_valE};
    if (s == 4'hF) return 64'd0;
    for (int k = 0; k < 5; k++) if (ids[k] == s) return vals[k];
    return m_rf[s];
  endfunction

  task automatic check_all(input string ph);
    logic [3:0]  ea, eb, ee, em;
    logic [63:0] va;
    ea = (m_icode inside {4'h2, 4'h4, 4'h6, 4'hA}) ? m_ra : (m_icode inside {4'h9, 4'hB}) ? 4'h4 : 4'hF;
    eb = (m_icode inside {4'h4, 4'h5, 4'h6}) ? m_rb : (m_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    ee = (m_icode inside {4'h2, 4'h3, 4'h6}) ? m_rb : (m_icode inside {4'h8, 4'h9, 4'hA, 4'hB}) ? 4'h4 : 4'hF;
    em = (m_icode inside {4'h5, 4'hB}) ? m_ra : 4'hF;
    va = (m_icode inside {4'h7, 4'h8}) ? m_valp : lookup(ea);
    check_val({ph, ".stat"},  64'(d_stat),  64'(m_stat));
    check_val({ph, ".icode"}, 64'(d_icode), 64'(m_icode));
    check_val({ph, ".ifun"},  64'(d_ifun),  64'(m_ifun));
    check_val({ph, ".valC"},  d_valC, m_valc);
    check_val({ph, ".srcA"},  64'(d_srcA), 64'(ea));
    check_val({ph, ".srcB"},  64'(d_srcB), 64'(eb));
    check_val({ph, ".dstE"},  64'(d_dstE), 64'(ee));
    check_val({ph, ".dstM"},  64'(d_dstM), 64'(em));
    check_val({ph, ".valA"},  d_valA, va);
    check_val({ph, ".valB"},  d_valB, lookup(eb));
  endtask

  task automatic fwd_none();
    e_dstE = 4'hF; M_dstM = 4'hF; M_dstE = 4'hF; W_dstM = 4'hF; W_dstE = 4'hF;
  endtask

  task automatic fetch(input logic [3:0] ic, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [63:0] vc, input logic [63:0] vp);
    f_stat = 3'd1; f_icode = ic; f_ifun = 4'h0; f_rA = ra; f_rB = rb; f_valC = vc; f_valP = vp;
  endtask

  function automatic logic [3:0] rand_id();
    logic [3:0] r;
    r = 4'($urandom_range(0, 7));
    return (r == 4'd7) ? 4'hF : r;
  endfunction

  initial begin
    for (int i = 0; i < 15; i++) m_rf[i] = 64'd0;
    model_nop();
    rst = 1'b1; D_stall = 1'b0; D_bubble = 1'b0;
    fetch(4'h6, 4'h1, 4'h2, 64'h1234, 64'h5678);
    fwd_none();
    e_valE = 64'd0; m_valM = 64'd0; M_valE = 64'd0; W_valM = 64'd0; W_valE = 64'd0;
    W_dstE = 4'h1; W_valE = 64'hDEAD;   // writeback on the reset edge must be dropped
    @(negedge clk);
    tick();
    rst = 1'b0;
    fwd_none();
    #1;
    check_val("rst.icode", 64'(d_icode), 64'd1);
    check_val("rst.stat",  64'(d_stat),  64'd1);
    check_val("rst.srcA",  64'(d_srcA),  64'hF);
    check_val("rst.srcB",  64'(d_srcB),  64'hF);
    check_val("rst.dstE",  64'(d_dstE),  64'hF);
    check_val("rst.dstM",  64'(d_dstM),  64'hF);
    check_val("rst.valA",  d_valA, 64'd0);
    check_val("rst.valB",  d_valB, 64'd0);
    for (int i = 0; i < 15; i++) begin
      fetch(4'h6, 4'(i), 4'(i), 64'd0, 64'd0);
      tick(); #1;
      check_val($sformatf("rst.rf%0d.a", i), d_valA, 64'd0);
      check_val($sformatf("rst.rf%0d.b", i), d_valB, 64'd0);
    end

    fetch(4'h3, 4'hF, 4'h2, 64'h10, 64'h0);
    tick(); #1;
    check_val("irmov.dstE", 64'(d_dstE), 64'd2);
    check_val("irmov.srcA", 64'(d_srcA), 64'hF);
    check_val("irmov.srcB", 64'(d_srcB), 64'hF);
    check_val("irmov.valC", d_valC, 64'h10);

    W_dstE = 4'h3; W_valE = 64'hAA;
    fetch(4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
    tick();
    fwd_none();
    fetch(4'h6, 4'h3, 4'h3, 64'd0, 64'd0);
    tick(); #1;
    check_val("wb.valA", d_valA, 64'hAA);
    check_val("wb.valB", d_valB, 64'hAA);

    fetch(4'h6, 4'h5, 4'hF, 64'd0, 64'd0);
    tick();
    e_dstE = 4'h5; e_valE = 64'd1; M_dstM = 4'h5; m_valM = 64'd2; W_dstE = 4'h5; W_valE = 64'd3;
    #1; check_val("fwd.e", d_valA, 64'd1);
    e_dstE = 4'hF; #1; check_val("fwd.m", d_valA, 64'd2);
    M_dstM = 4'hF; #1; check_val("fwd.w", d_valA, 64'd3);
    fwd_none();

    fetch(4'h8, 4'hF, 4'hF, 64'h100, 64'h40);
    tick(); #1;
    check_val("call.valA", d_valA, 64'h40);
    check_val("call.srcB", 64'(d_srcB), 64'd4);
    check_val("call.dstE", 64'(d_dstE), 64'd4);
    fetch(4'h3, 4'hF, 4'h1, 64'h7, 64'h0);
    D_stall = 1'b1; D_bubble = 1'b1;
    tick(); #1; check_val("both.icode", 64'(d_icode), 64'd8);
    D_bubble = 1'b0;
    tick(); #1; check_val("stall.icode", 64'(d_icode), 64'd8);
    D_stall = 1'b0; D_bubble = 1'b1;
    tick(); #1; check_val("bubble.icode", 64'(d_icode), 64'd1);
    check_val("bubble.srcA", 64'(d_srcA), 64'hF);
    D_bubble = 1'b0;

    W_dstE = 4'h4; W_valE = 64'd8; W_dstM = 4'h4; W_valM = 64'h55;
    fetch(4'h1, 4'hF, 4'hF, 64'd0, 64'd0);
    tick();
    fwd_none();
    fetch(4'h9, 4'hF, 4'hF, 64'd0, 64'd0);
    tick(); #1;
    check_val("dual.valA", d_valA, 64'h55);
    check_val("dual.valB", d_valB, 64'h55);
    check_all("dir");

    for (int n = 0; n < 400; n++) begin
      rst      = ($urandom_range(0, 49) == 0);
      D_stall  = ($urandom_range(0, 7) == 0);
      D_bubble = ($urandom_range(0, 7) == 0);
      f_stat   = 3'($urandom_range(1, 4));
      f_icode  = 4'($urandom_range(0, 15));
      f_ifun   = 4'($urandom_range(0, 15));
      f_rA     = rand_id();
      f_rB     = rand_id();
      f_valC   = {$urandom, $urandom};
      f_valP   = {$urandom, $urandom};
      e_dstE = rand_id(); M_dstM = rand_id(); M_dstE = rand_id();
      W_dstM = rand_id(); W_dstE = rand_id();
      e_valE = {$urandom, $urandom}; m_valM = {$urandom, $urandom};
      M_valE = {$urandom, $urandom}; W_valM = {$urandom, $urandom};
      W_valE = {$urandom, $urandom};
      #1;
      check_all("rnd");
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
